// File: rtl/mbox_handshake_if.sv
// mbox_handshake_if
//   Bundles the SAM doorbell pair and the Avalon-MM register port of the
//   mailbox bridge.
//   mb_rq               request from the SAM (asynchronous to the bridge clock)
//   mb_ak               acknowledge back to the SAM
//   avl_address[1:0]    register address
//   avl_read            read strobe
//   avl_write           write strobe
//   avl_write_data[31:0]
//   avl_read_data[31:0] registered read data
//   avl_read_datavalid  one cycle after avl_read
//   irq                 level interrupt to the CPU
//   slave modport: the bridge.  master modport: SAM + CPU side.
interface mbox_handshake_if;
    logic        mb_rq;
    logic        mb_ak;
    logic [1:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_write_data;
    logic [31:0] avl_read_data;
    logic        avl_read_datavalid;
    logic        irq;

    modport slave (
        input  mb_rq, avl_address, avl_read, avl_write, avl_write_data,
        output mb_ak, avl_read_data, avl_read_datavalid, irq
    );

    modport master (
        output mb_rq, avl_address, avl_read, avl_write, avl_write_data,
        input  mb_ak, avl_read_data, avl_read_datavalid, irq
    );
endinterface

// File: rtl/mbox_handshake.sv
// mbox_handshake
//   Mailbox doorbell bridge: synchronises the SAM request, runs a four-phase
//   req/ack handshake and exposes status/ack, a completed-transfer counter
//   and an optional timeout through a small Avalon-MM slave.
//   Ports:
//     iCLK     system clock (single domain)
//     iRESETn  synchronous active-low reset
//     bus      mbox_handshake_if.slave (doorbell pair, register port, irq)
//   Registers: 0 STATUS, 1 COUNT, 2 TIMEOUT, 3 unmapped (reads 0).
//   Optional feature macro: MBOX_TIMEOUT_EN builds the timeout counter,
//   the TIMEOUT register and the TMO flag; without it PENDING only exits on
//   abort or CPU ack and address 2 / STATUS bit2 read 0.
//   SYNC_STAGES must be >= 2; CNT_W and TMO_W must be <= 32.
module mbox_handshake #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TMO_W       = 24
) (
    input  logic             iCLK,
    input  logic             iRESETn,
    mbox_handshake_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rq_s;
    logic                   ak, irq, irq_en, abort;
    logic [CNT_W-1:0]       count;
    logic [31:0]            rd_data;
    logic                   rd_valid;
    logic                   pending;
    logic                   wr_status, wr_count;
    logic                   abort_set, tmo_set, cnt_inc;
    logic                   tmo, tmo_hit;
    logic [31:0]            status_word, timeout_word, rd_mux;
    logic                   unused_wd;

    assign unused_wd = ^bus.avl_write_data;

    // Request synchroniser; rq_s is the oldest stage.
    always_ff @(posedge iCLK) begin
        if (!iRESETn) sync <= '0;
        else          sync <= {sync[SYNC_STAGES-2:0], bus.mb_rq};
    end
    assign rq_s = sync[SYNC_STAGES-1];

    assign pending   = (state == PENDING);
    assign wr_status = bus.avl_write && (bus.avl_address == 2'd0);
    assign wr_count  = bus.avl_write && (bus.avl_address == 2'd1);

`ifdef MBOX_TIMEOUT_EN
    logic [TMO_W-1:0] timeout, tmo_cnt;
    logic             wr_tmo;

    assign wr_tmo       = bus.avl_write && (bus.avl_address == 2'd2);
    assign tmo_hit      = (timeout != '0) && (tmo_cnt == timeout - TMO_W'(1));
    assign timeout_word = 32'(timeout);

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            timeout <= '0;
            tmo_cnt <= '0;
            tmo     <= 1'b0;
        end else begin
            if (wr_tmo) timeout <= bus.avl_write_data[TMO_W-1:0];
            if (state == IDLE)         tmo_cnt <= '0;
            else if (state == PENDING) tmo_cnt <= tmo_cnt + TMO_W'(1);
            // set beats a same-cycle clear
            if (tmo_set)                                    tmo <= 1'b1;
            else if (wr_status && bus.avl_write_data[2])    tmo <= 1'b0;
        end
    end
`else
    localparam int unused_tmo_w = TMO_W;
    assign tmo          = 1'b0;
    assign tmo_hit      = 1'b0;
    assign timeout_word = '0;
`endif

    // Next state; PENDING exit priority is abort > CPU ack > timeout.
    always_comb begin
        state_next = state;
        abort_set  = 1'b0;
        tmo_set    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE:    if (rq_s) state_next = PENDING;
            PENDING: begin
                if (!rq_s) begin
                    abort_set  = 1'b1;
                    state_next = IDLE;
                end else if (wr_status && bus.avl_write_data[0]) begin
                    state_next = ACK;
                end else if (tmo_hit) begin
                    tmo_set    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     if (!rq_s) state_next = RELEASE;
            RELEASE: begin
                cnt_inc    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        status_word      = '0;
        status_word[0]   = pending;
        status_word[1]   = ak;
        status_word[2]   = tmo;
        status_word[3]   = abort;
        status_word[5:4] = state;
        status_word[8]   = irq_en;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.avl_address)
            2'd0:    rd_mux = status_word;
            2'd1:    rd_mux = 32'(count);
            2'd2:    rd_mux = timeout_word;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            state    <= IDLE;
            ak       <= 1'b0;
            abort    <= 1'b0;
            irq_en   <= 1'b0;
            count    <= '0;
            irq      <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state <= state_next;
            ak    <= (state_next == ACK);
            if (abort_set)                                abort <= 1'b1;
            else if (wr_status && bus.avl_write_data[3])  abort <= 1'b0;
            if (wr_status) irq_en <= bus.avl_write_data[8];
            // a COUNT write beats a same-cycle increment
            if (wr_count)     count <= '0;
            else if (cnt_inc) count <= count + CNT_W'(1);
            irq      <= irq_en & (pending | tmo | abort);
            rd_valid <= bus.avl_read;
            if (bus.avl_read) rd_data <= rd_mux;
        end
    end

    assign bus.mb_ak              = ak;
    assign bus.irq                = irq;
    assign bus.avl_read_data      = rd_data;
    assign bus.avl_read_datavalid = rd_valid;

endmodule
